// File: rtl/hazard_fwd_scoreboard.sv
// hazard_fwd_scoreboard: hazard detection and forwarding controller for the pipelined MIPS core.
// Tracks destination-register metadata for DEPTH stages after ID (stage 1 = EX, stage DEPTH = WB).
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   id_valid_i                    ID holds a real instruction
//   id_rs_i, id_rt_i              ID source registers, id_uses_rs_i/id_uses_rt_i mark real reads
//   id_rd_i                       ID destination (already reg_dst-muxed)
//   id_reg_write_i, id_mem_read_i ID control bits
//   flush_i                       kill the ID instruction
//   stall_o                       hold PC and IF/ID, bubble into EX
//   fwd_a_o, fwd_b_o              EX operand source: 0 = register file, k = stage k result
//   stall_count_o                 saturating count of stall cycles
// Macro HAZARD_FWD_EN: defined gives forwarding with load-use stalls; undefined gives a
// no-forwarding build that stalls on any in-flight producer hit.
module hazard_fwd_scoreboard #(
  parameter int REG_AW     = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_AVAIL = 3,
  parameter int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_uses_rs_i,
  input  logic              id_uses_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_reg_write_i,
  input  logic              id_mem_read_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic [SEL_W-1:0]  fwd_a_o,
  output logic [SEL_W-1:0]  fwd_b_o,
  output logic [15:0]       stall_count_o
);
  logic [DEPTH:1]    v_q, wr_q, ld_q, prod;
  logic [DEPTH-1:1]  id_hit;
  logic [REG_AW-1:0] rd_q [1:DEPTH];
  logic [REG_AW-1:0] rs_q, rt_q;
  logic              urs_q, urt_q;
  logic              bubble;
  logic [15:0]       cnt_q, cnt_d;

  // Register 0 is never a producer, so writes to it can't create hazards.
  always_comb begin
    for (int k = 1; k <= DEPTH; k++)
      prod[k] = v_q[k] & wr_q[k] & (rd_q[k] != '0);
  end

  // Stage DEPTH is excluded: the register file is write-through for ID.
  always_comb begin
    for (int k = 1; k < DEPTH; k++)
      id_hit[k] = prod[k] & ((id_uses_rs_i & (rd_q[k] == id_rs_i)) |
                             (id_uses_rt_i & (rd_q[k] == id_rt_i)));
  end

  always_comb begin
    stall_o = 1'b0;
    for (int k = 1; k < DEPTH; k++)
`ifdef HAZARD_FWD_EN
      stall_o |= id_hit[k] & ld_q[k] & (k + 1 < LOAD_AVAIL);
`else
      stall_o |= id_hit[k];
`endif
    stall_o &= id_valid_i;
  end

`ifdef HAZARD_FWD_EN
  // Scan oldest to youngest so the youngest qualifying producer wins.
  always_comb begin
    fwd_a_o = '0;
    fwd_b_o = '0;
    for (int k = DEPTH; k >= 2; k--)
      if (prod[k] && (!ld_q[k] || k >= LOAD_AVAIL)) begin
        if (v_q[1] && urs_q && rd_q[k] == rs_q) fwd_a_o = SEL_W'(k);
        if (v_q[1] && urt_q && rd_q[k] == rt_q) fwd_b_o = SEL_W'(k);
      end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{rs_q, rt_q, urs_q, urt_q, ld_q, prod[DEPTH]};
  assign fwd_a_o = '0;
  assign fwd_b_o = '0;
`endif

  // Stall and flush both insert an all-zero bubble into stage 1.
  assign bubble        = stall_o | flush_i | ~id_valid_i;
  assign cnt_d         = (stall_o && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  assign stall_count_o = cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v_q   <= '0;
      wr_q  <= '0;
      ld_q  <= '0;
      rs_q  <= '0;
      rt_q  <= '0;
      urs_q <= 1'b0;
      urt_q <= 1'b0;
      cnt_q <= '0;
      for (int k = 1; k <= DEPTH; k++) rd_q[k] <= '0;
    end else begin
      v_q     <= {v_q[DEPTH-1:1], ~bubble};
      wr_q    <= {wr_q[DEPTH-1:1], ~bubble & id_reg_write_i};
      ld_q    <= {ld_q[DEPTH-1:1], ~bubble & id_mem_read_i};
      rd_q[1] <= bubble ? '0 : id_rd_i;
      for (int k = 2; k <= DEPTH; k++) rd_q[k] <= rd_q[k-1];
      rs_q    <= bubble ? '0 : id_rs_i;
      rt_q    <= bubble ? '0 : id_rt_i;
      urs_q   <= ~bubble & id_uses_rs_i;
      urt_q   <= ~bubble & id_uses_rt_i;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_hazard_fwd_scoreboard.sv
// tb_hazard_fwd_scoreboard: directed checks of forwarding, load-use stalls, flush, reset and counter saturation
module tb_hazard_fwd_scoreboard;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, urs, urt, wr, mr, flush;
  logic [4:0]  rs, rt, rd;
  logic        stall;
  logic [1:0]  fa, fb;
  logic [15:0] cnt;
  logic        s_valid, s_stall;
  logic [5:0]  s_fa, s_fb;
  logic [15:0] s_cnt;
  int          total = 0, bad = 0, exp_cnt = 0;

  always #5 clk = ~clk;

  hazard_fwd_scoreboard dut (
    .clk_i(clk), .rst_ni(rst_n), .id_valid_i(id_valid), .id_rs_i(rs), .id_rt_i(rt),
    .id_uses_rs_i(urs), .id_uses_rt_i(urt), .id_rd_i(rd), .id_reg_write_i(wr),
    .id_mem_read_i(mr), .flush_i(flush), .stall_o(stall), .fwd_a_o(fa), .fwd_b_o(fb),
    .stall_count_o(cnt)
  );

  // Deep load latency so a self-dependent load chain stalls almost every cycle.
  hazard_fwd_scoreboard #(.DEPTH(32), .LOAD_AVAIL(32)) u_sat (
    .clk_i(clk), .rst_ni(rst_n), .id_valid_i(s_valid), .id_rs_i(5'd5), .id_rt_i(5'd0),
    .id_uses_rs_i(1'b1), .id_uses_rt_i(1'b0), .id_rd_i(5'd5), .id_reg_write_i(1'b1),
    .id_mem_read_i(1'b1), .flush_i(1'b0), .stall_o(s_stall), .fwd_a_o(s_fa), .fwd_b_o(s_fb),
    .stall_count_o(s_cnt)
  );

  task automatic id(input logic v, input logic [4:0] s, t, input logic us, ut,
                    input logic [4:0] d, input logic w, m);
    id_valid = v; rs = s; rt = t; urs = us; urt = ut; rd = d; wr = w; mr = m;
    #1;
  endtask

  task automatic nop();
    id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    nop();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; s_valid = 1'b0;
    nop();
    #11;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0d exp=0", stall); end
    total++; if (fa !== 2'd0) begin bad++; $display("FAIL rst_fwd_a got=%0d exp=0", fa); end
    total++; if (fb !== 2'd0) begin bad++; $display("FAIL rst_fwd_b got=%0d exp=0", fb); end
    total++; if (cnt !== 16'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", cnt); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alu_alu();
    id(1, 1, 1, 1, 1, 3, 1, 0);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL alu_prod_stall got=%0d exp=0", stall); end
    tick();
    id(1, 3, 1, 1, 1, 4, 1, 0);
`ifdef HAZARD_FWD_EN
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL alu_cons_stall got=%0d exp=0", stall); end
    tick();
    nop();
    total++; if (fa !== 2'd2) begin bad++; $display("FAIL alu_fwd_a got=%0d exp=2", fa); end
    total++; if (fb !== 2'd0) begin bad++; $display("FAIL alu_fwd_b got=%0d exp=0", fb); end
`else
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL alu_stall1 got=%0d exp=1", stall); end
    tick();
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL alu_stall2 got=%0d exp=1", stall); end
    tick();
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL alu_stall3 got=%0d exp=0", stall); end
    exp_cnt += 2;
    tick();
    nop();
    total++; if (fa !== 2'd0) begin bad++; $display("FAIL alu_fwd_a got=%0d exp=0", fa); end
`endif
    total++; if (cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL alu_count got=%0d exp=%0d", cnt, exp_cnt); end
    idle();
  endtask

  task automatic test_load_use();
    id(1, 1, 0, 1, 0, 5, 1, 1);
    tick();
    id(1, 5, 5, 1, 1, 6, 1, 0);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu_stall1 got=%0d exp=1", stall); end
    tick();
`ifdef HAZARD_FWD_EN
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_stall2 got=%0d exp=0", stall); end
    exp_cnt += 1;
    total++; if (cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL lu_count got=%0d exp=%0d", cnt, exp_cnt); end
    tick();
    nop();
    total++; if (fa !== 2'd3) begin bad++; $display("FAIL lu_fwd_a got=%0d exp=3", fa); end
    total++; if (fb !== 2'd3) begin bad++; $display("FAIL lu_fwd_b got=%0d exp=3", fb); end
`else
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu_stall2 got=%0d exp=1", stall); end
    tick();
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_stall3 got=%0d exp=0", stall); end
    exp_cnt += 2;
    total++; if (cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL lu_count got=%0d exp=%0d", cnt, exp_cnt); end
    tick();
    nop();
    total++; if (fa !== 2'd0) begin bad++; $display("FAIL lu_fwd_a got=%0d exp=0", fa); end
    total++; if (fb !== 2'd0) begin bad++; $display("FAIL lu_fwd_b got=%0d exp=0", fb); end
`endif
    idle();
  endtask

  task automatic test_reg_zero();
    id(1, 1, 1, 1, 1, 0, 1, 0);
    tick();
    id(1, 0, 0, 1, 1, 7, 1, 0);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL r0_stall got=%0d exp=0", stall); end
    tick();
    nop();
    total++; if (fa !== 2'd0) begin bad++; $display("FAIL r0_fwd_a got=%0d exp=0", fa); end
    total++; if (fb !== 2'd0) begin bad++; $display("FAIL r0_fwd_b got=%0d exp=0", fb); end
    idle();
  endtask

  task automatic test_double_producer();
    id(1, 1, 1, 1, 1, 2, 1, 0);
    tick();
    id(1, 1, 1, 1, 1, 2, 1, 0);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL dbl_prod_stall got=%0d exp=0", stall); end
    tick();
    id(1, 2, 9, 1, 1, 10, 1, 0);
`ifdef HAZARD_FWD_EN
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL dbl_stall got=%0d exp=0", stall); end
    tick();
    nop();
    total++; if (fa !== 2'd2) begin bad++; $display("FAIL dbl_fwd_a got=%0d exp=2", fa); end
`else
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL dbl_stall got=%0d exp=1", stall); end
    tick();
    tick();
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL dbl_stall_end got=%0d exp=0", stall); end
    exp_cnt += 2;
    total++; if (cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL dbl_count got=%0d exp=%0d", cnt, exp_cnt); end
    tick();
    nop();
    total++; if (fa !== 2'd0) begin bad++; $display("FAIL dbl_fwd_a got=%0d exp=0", fa); end
`endif
    idle();
    id(1, 1, 1, 1, 1, 2, 1, 0);
    tick();
    id(1, 1, 1, 1, 1, 9, 1, 0);
    tick();
    id(1, 2, 8, 1, 1, 10, 1, 0);
`ifdef HAZARD_FWD_EN
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL gap_stall got=%0d exp=0", stall); end
    tick();
    nop();
    total++; if (fa !== 2'd3) begin bad++; $display("FAIL gap_fwd_a got=%0d exp=3", fa); end
`else
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL gap_stall got=%0d exp=1", stall); end
    tick();
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL gap_stall_end got=%0d exp=0", stall); end
    exp_cnt += 1;
    tick();
    nop();
    total++; if (fa !== 2'd0) begin bad++; $display("FAIL gap_fwd_a got=%0d exp=0", fa); end
`endif
    total++; if (cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL gap_count got=%0d exp=%0d", cnt, exp_cnt); end
    idle();
  endtask

  task automatic test_flush_stall();
    id(1, 1, 0, 1, 0, 5, 1, 1);
    tick();
    flush = 1'b1;
    id(1, 5, 1, 1, 1, 6, 1, 0);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL fl_stall got=%0d exp=1", stall); end
    tick();
    flush = 1'b0;
    id(1, 6, 6, 1, 1, 11, 1, 0);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL fl_cons_stall got=%0d exp=0", stall); end
    exp_cnt += 1;
    total++; if (cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL fl_count got=%0d exp=%0d", cnt, exp_cnt); end
    tick();
    nop();
    total++; if (fa !== 2'd0) begin bad++; $display("FAIL fl_fwd_a got=%0d exp=0", fa); end
    total++; if (fb !== 2'd0) begin bad++; $display("FAIL fl_fwd_b got=%0d exp=0", fb); end
    idle();
    flush = 1'b1;
    id(1, 1, 1, 1, 1, 6, 1, 0);
    tick();
    flush = 1'b0;
    id(1, 6, 6, 1, 1, 12, 1, 0);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL fl2_stall got=%0d exp=0", stall); end
    tick();
    nop();
    total++; if (fa !== 2'd0) begin bad++; $display("FAIL fl2_fwd_a got=%0d exp=0", fa); end
    total++; if (cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL fl2_count got=%0d exp=%0d", cnt, exp_cnt); end
    idle();
  endtask

  task automatic test_reset_mid();
    id(1, 1, 0, 1, 0, 3, 1, 1);
    tick();
    id(1, 3, 3, 1, 1, 4, 1, 0);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL rm_pre_stall got=%0d exp=1", stall); end
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rm_stall got=%0d exp=0", stall); end
    total++; if (fa !== 2'd0) begin bad++; $display("FAIL rm_fwd_a got=%0d exp=0", fa); end
    total++; if (cnt !== 16'd0) begin bad++; $display("FAIL rm_count got=%0d exp=0", cnt); end
    #2 rst_n = 1'b1;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rm_post_stall got=%0d exp=0", stall); end
    tick();
    nop();
    total++; if (fa !== 2'd0) begin bad++; $display("FAIL rm_post_fwd_a got=%0d exp=0", fa); end
    total++; if (fb !== 2'd0) begin bad++; $display("FAIL rm_post_fwd_b got=%0d exp=0", fb); end
    idle();
`ifdef HAZARD_FWD_EN
    id(1, 1, 1, 1, 1, 3, 1, 0);
    tick();
    id(1, 3, 1, 1, 1, 4, 1, 0);
    tick();
    nop();
    total++; if (fa !== 2'd2) begin bad++; $display("FAIL rf_pre_fwd_a got=%0d exp=2", fa); end
    rst_n = 1'b0;
    #1;
    total++; if (fa !== 2'd0) begin bad++; $display("FAIL rf_fwd_a got=%0d exp=0", fa); end
    #1 rst_n = 1'b1;
    idle();
`endif
  endtask

  task automatic test_saturation();
    logic seen = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 69000 && s_cnt !== 16'hFFFF; i++) tick();
    total++; if (s_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_reach got=%0h exp=ffff", s_cnt); end
    repeat (40) begin
      tick();
      if (s_stall === 1'b1) seen = 1'b1;
    end
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL sat_stalling got=%0d exp=1", seen); end
    total++; if (s_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%0h exp=ffff", s_cnt); end
    s_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu_alu();
    test_load_use();
    test_reg_zero();
    test_double_producer();
    test_flush_stall();
    test_reset_mid();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
